// File: rtl/irq_pending_ctrl_pkg.sv
// Shared types and constants for the pending-request interrupt controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package irq_pkg;

  localparam int NCH  = 4;
  localparam int ID_W = 2;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_ISSUE = 1'b1
  } state_t;

  // Channel number to one-hot channel vector.
  function automatic logic [NCH-1:0] id_onehot(input logic [ID_W-1:0] id);
    logic [NCH-1:0] oh;
    oh     = '0;
    oh[id] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/irq_pending_ctrl_if.sv
// Request/mask inputs and the issued-channel valid/ack handshake.
// Latency: n/a (wiring only).
// Backpressure: irq_valid holds until the consumer drives ack.
interface irq_pending_ctrl_if;
  import irq_pkg::*;

  logic            en;
  logic [NCH-1:0]  req;
  logic [NCH-1:0]  mask;
  logic            ack;
  logic            ovf_clr;
  logic [NCH-1:0]  pending;
  logic            irq_valid;
  logic [ID_W-1:0] irq_id;
  logic [NCH-1:0]  ovf;

  // Controller side.
  modport slave (
    input  en, req, mask, ack, ovf_clr,
    output pending, irq_valid, irq_id, ovf
  );

  // Requester / consumer side.
  modport master (
    output en, req, mask, ack, ovf_clr,
    input  pending, irq_valid, irq_id, ovf
  );

endinterface

// File: rtl/irq_pending_ctrl_enc.sv
// Combinational 4-to-2 priority encoder, bit 3 highest priority.
// Latency: 0 cycles.
// Backpressure: none; vld is low when en=0 or no input bit is set.
module priority_enc_4to2
  import irq_pkg::*;
(
  input  logic [NCH-1:0]  in_vec,
  input  logic            en,
  output logic [ID_W-1:0] id,
  output logic            vld
);

  // Highest set bit wins; id defaults to 0 when nothing is requested.
  always_comb begin
    id  = '0;
    vld = 1'b0;
    if (en) begin
      vld = 1'b1;
      casez (in_vec)
        4'b1???: id = 2'd3;
        4'b01??: id = 2'd2;
        4'b001?: id = 2'd1;
        4'b0001: id = 2'd0;
        default: vld = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/irq_pending_ctrl.sv
// Captures request events into a pending vector and issues one channel at a time.
// Latency: req event to pending 1 cycle, pending to irq_valid 1 cycle (2 total).
// Backpressure: an issued channel is held until ack; at most one grant per ack.
module irq_pending_ctrl #(
  parameter bit EDGE_MODE = 1'b1,
  parameter int NCH       = 4
) (
  input  logic               clk,
  input  logic               rst,
  irq_pending_ctrl_if.slave  bus
);
  import irq_pkg::*;

  if (NCH != 4) begin : g_nch_bad
    $error("irq_pending_ctrl: NCH must be 4 to match the encoder width");
  end

  logic [NCH-1:0]  req_q, req_d;
  logic [NCH-1:0]  pending_q, pending_d;
  logic [NCH-1:0]  ovf_q, ovf_d;
  logic            irq_valid_q, irq_valid_d;
  logic [ID_W-1:0] irq_id_q, irq_id_d;
  state_t          state_q, state_d;

  logic [NCH-1:0]  ev;
  logic [NCH-1:0]  clr;
  logic [NCH-1:0]  masked;
  logic [ID_W-1:0] enc_id;
  logic            enc_vld;

  // Event detect, pending capture (set beats clear) and sticky overflow.
  always_comb begin
    req_d     = bus.req;
    ev        = EDGE_MODE ? (bus.req & ~req_q) : bus.req;
    clr       = (bus.ack && irq_valid_q) ? id_onehot(irq_id_q) : '0;
    pending_d = (pending_q & ~clr) | ev;
    ovf_d     = '0;
    if (EDGE_MODE) begin
      ovf_d = (bus.ovf_clr ? '0 : ovf_q) | (ev & pending_q & ~clr);
    end
  end

  assign masked = pending_q & bus.mask;

  priority_enc_4to2 u_enc (
    .in_vec (masked),
    .en     (bus.en),
    .id     (enc_id),
    .vld    (enc_vld)
  );

  // Grant FSM: latch the encoder result in IDLE, freeze it until ack in ISSUE.
  always_comb begin
    state_d     = state_q;
    irq_valid_d = irq_valid_q;
    irq_id_d    = irq_id_q;
    case (state_q)
      S_IDLE: begin
        if (enc_vld) begin
          state_d     = S_ISSUE;
          irq_valid_d = 1'b1;
          irq_id_d    = enc_id;
        end
      end
      S_ISSUE: begin
        if (bus.ack) begin
          state_d     = S_IDLE;
          irq_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = S_IDLE;
        irq_valid_d = 1'b0;
      end
    endcase
  end

  // State register; req_q resets high so lines held at reset release are not edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q       <= '1;
      pending_q   <= '0;
      ovf_q       <= '0;
      irq_valid_q <= 1'b0;
      irq_id_q    <= '0;
      state_q     <= S_IDLE;
    end else begin
      req_q       <= req_d;
      pending_q   <= pending_d;
      ovf_q       <= ovf_d;
      irq_valid_q <= irq_valid_d;
      irq_id_q    <= irq_id_d;
      state_q     <= state_d;
    end
  end

  assign bus.pending   = pending_q;
  assign bus.irq_valid = irq_valid_q;
  assign bus.irq_id    = irq_id_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Directed bench for irq_pending_ctrl: edge-mode instance plus a level-mode instance.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: consumer ack is driven explicitly by the stimulus.
module tb_irq_pending_ctrl;

  logic clk;
  logic rst;
  logic rst_l;
  int   total;
  int   bad;

  irq_pending_ctrl_if bus_e ();
  irq_pending_ctrl_if bus_l ();

  irq_pending_ctrl #(.EDGE_MODE(1'b1), .NCH(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_e)
  );

  irq_pending_ctrl #(.EDGE_MODE(1'b0), .NCH(4)) u_dut_lvl (
    .clk (clk),
    .rst (rst_l),
    .bus (bus_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expects a grant for exp_id, acks it, then checks the gap cycle and pending.
  task automatic service(input string tag, input logic [1:0] exp_id, input logic [3:0] exp_pend);
    chk({tag, "_vld"}, 32'(bus_e.irq_valid), 32'd1);
    chk({tag, "_id"}, 32'(bus_e.irq_id), 32'(exp_id));
    bus_e.ack = 1'b1;
    step();
    bus_e.ack = 1'b0;
    chk({tag, "_gap"}, 32'(bus_e.irq_valid), 32'd0);
    chk({tag, "_pend"}, 32'(bus_e.pending), 32'(exp_pend));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    rst_l = 1'b1;
    bus_e.en = 1'b1; bus_e.req = 4'b1111; bus_e.mask = 4'b1111;
    bus_e.ack = 1'b0; bus_e.ovf_clr = 1'b0;
    bus_l.en = 1'b1; bus_l.req = 4'b0000; bus_l.mask = 4'b1111;
    bus_l.ack = 1'b0; bus_l.ovf_clr = 1'b0;
    step();
    step();

    // 1: reset state, no edges from lines held high across release
    chk("rst_pend", 32'(bus_e.pending), 32'h0);
    chk("rst_vld", 32'(bus_e.irq_valid), 32'h0);
    chk("rst_id", 32'(bus_e.irq_id), 32'h0);
    chk("rst_ovf", 32'(bus_e.ovf), 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("held_pend", 32'(bus_e.pending), 32'h0);
      chk("held_vld", 32'(bus_e.irq_valid), 32'h0);
    end
    bus_e.req = 4'b0000;
    step();
    bus_e.req = 4'b0100;
    step();
    bus_e.req = 4'b0000;
    chk("t1_pend", 32'(bus_e.pending), 32'h4);
    chk("t1_vld0", 32'(bus_e.irq_valid), 32'h0);
    step();
    service("t1", 2'd2, 4'b0000);

    // ack while idle is ignored
    bus_e.ack = 1'b1;
    step();
    bus_e.ack = 1'b0;
    chk("idle_ack_vld", 32'(bus_e.irq_valid), 32'h0);
    chk("idle_ack_pend", 32'(bus_e.pending), 32'h0);

    // 2: simultaneous requests served in priority order 3, 1, 0
    bus_e.req = 4'b1011;
    step();
    bus_e.req = 4'b0000;
    chk("t2_pend", 32'(bus_e.pending), 32'hb);
    step();
    service("t2a", 2'd3, 4'b0011);
    step();
    service("t2b", 2'd1, 4'b0001);
    step();
    service("t2c", 2'd0, 4'b0000);

    // 3: higher-priority arrival does not preempt an issued grant
    bus_e.req = 4'b0010;
    step();
    bus_e.req = 4'b0000;
    step();
    chk("t3_id1", 32'(bus_e.irq_id), 32'h1);
    bus_e.req = 4'b1000;
    step();
    bus_e.req = 4'b0000;
    chk("t3_pend", 32'(bus_e.pending), 32'ha);
    chk("t3_id2", 32'(bus_e.irq_id), 32'h1);
    step();
    service("t3a", 2'd1, 4'b1000);
    step();
    service("t3b", 2'd3, 4'b0000);

    // 4: masked channel latches but is not issued until unmasked
    bus_e.mask = 4'b0111;
    bus_e.req  = 4'b1000;
    step();
    bus_e.req = 4'b0000;
    step();
    step();
    chk("t4_pend", 32'(bus_e.pending), 32'h8);
    chk("t4_vld0", 32'(bus_e.irq_valid), 32'h0);
    bus_e.mask = 4'b1111;
    step();
    service("t4", 2'd3, 4'b0000);

    // 5: overflow, set-beats-clear on the ack cycle, ovf_clr
    bus_e.req = 4'b0001;
    step();
    bus_e.req = 4'b0000;
    step();
    chk("t5_issue", 32'(bus_e.irq_valid), 32'h1);
    bus_e.req = 4'b0001;
    step();
    bus_e.req = 4'b0000;
    chk("t5_ovf", 32'(bus_e.ovf), 32'h1);
    chk("t5_pend", 32'(bus_e.pending), 32'h1);
    step();
    bus_e.req = 4'b0001;
    bus_e.ack = 1'b1;
    step();
    bus_e.req = 4'b0000;
    bus_e.ack = 1'b0;
    chk("t5_ackset_pend", 32'(bus_e.pending), 32'h1);
    chk("t5_ackset_ovf", 32'(bus_e.ovf), 32'h1);
    chk("t5_ackset_vld", 32'(bus_e.irq_valid), 32'h0);
    step();
    chk("t5_reissue", 32'(bus_e.irq_valid), 32'h1);
    bus_e.ovf_clr = 1'b1;
    step();
    bus_e.ovf_clr = 1'b0;
    chk("t5_clr", 32'(bus_e.ovf), 32'h0);
    bus_e.req     = 4'b0001;
    bus_e.ovf_clr = 1'b1;
    step();
    bus_e.req     = 4'b0000;
    bus_e.ovf_clr = 1'b0;
    chk("t5_set_wins", 32'(bus_e.ovf), 32'h1);
    bus_e.ovf_clr = 1'b1;
    step();
    bus_e.ovf_clr = 1'b0;
    chk("t5_clr2", 32'(bus_e.ovf), 32'h0);
    service("t5", 2'd0, 4'b0000);

    // 6: en=0 blocks issue; reset during ISSUE drops the grant
    bus_e.en  = 1'b0;
    bus_e.req = 4'b0010;
    step();
    bus_e.req = 4'b0000;
    step();
    step();
    chk("t6_en_pend", 32'(bus_e.pending), 32'h2);
    chk("t6_en_vld", 32'(bus_e.irq_valid), 32'h0);
    bus_e.en = 1'b1;
    step();
    chk("t6_en_vld1", 32'(bus_e.irq_valid), 32'h1);
    chk("t6_en_id", 32'(bus_e.irq_id), 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_rst_pend", 32'(bus_e.pending), 32'h0);
    chk("t6_rst_vld", 32'(bus_e.irq_valid), 32'h0);
    chk("t6_rst_id", 32'(bus_e.irq_id), 32'h0);
    chk("t6_rst_ovf", 32'(bus_e.ovf), 32'h0);

    // 6: level mode re-issues a held request after every ack, never overflows
    rst_l     = 1'b0;
    bus_l.req = 4'b0001;
    step();
    chk("lvl_pend", 32'(bus_l.pending), 32'h1);
    step();
    for (int i = 0; i < 3; i++) begin
      chk("lvl_vld", 32'(bus_l.irq_valid), 32'h1);
      chk("lvl_id", 32'(bus_l.irq_id), 32'h0);
      bus_l.ack = 1'b1;
      step();
      bus_l.ack = 1'b0;
      chk("lvl_gap", 32'(bus_l.irq_valid), 32'h0);
      chk("lvl_pend_hold", 32'(bus_l.pending), 32'h1);
      chk("lvl_ovf", 32'(bus_l.ovf), 32'h0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/irq_pending_ctrl.md
Name: irq_pending_ctrl

Overview:
Four-channel request capture and service controller placed directly upstream of the 4-to-2 priority encoder. It latches request events into a pending register, masks them, and feeds the masked vector to the encoder. The encoded channel is presented to a consumer through a valid/ack handshake, and the serviced pending bit is cleared on acknowledge. The block turns the combinational encoder into a sequential interrupt-style arbiter.

Parameters:
EDGE_MODE, 1, 1 = pending set on rising edge of req[i]; 0 = pending set whenever req[i] is high (level)
NCH, 4, channel count; fixed at 4 (encoder width); any other value is a synthesis error

Ports:
clk  in  1  single clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
en  in  1  issue enable; 0 blocks new issues, capture continues
req  in  4  request lines, bit 3 highest priority
mask  in  4  1 = channel may be issued; masked channels still latch pending
ack  in  1  consumer acknowledge; meaningful only while irq_valid=1
ovf_clr  in  1  clears ovf register
pending  out  4  registered pending vector
irq_valid  out  1  an issued channel is held for the consumer
irq_id  out  2  issued channel number, stable while irq_valid=1
ovf  out  4  sticky per-channel overflow (event lost)

Behaviour:
- Reset (rst=1 at clk edge): pending=0, irq_valid=0, irq_id=0, ovf=0, FSM=IDLE, req_q=4'b1111. High req lines at reset release therefore do not count as edges in EDGE_MODE=1.
- Event: ev[i] = req[i] & ~req_q[i] (EDGE_MODE=1) or req[i] (EDGE_MODE=0). req_q <= req every cycle.
- Capture: pending[i] <= (pending[i] & ~clr[i]) | ev[i]. clr[i] = ack & irq_valid & (irq_id==i). Set wins over clear in the same cycle.
- Overflow (EDGE_MODE=1 only): ev[i] & pending[i] & ~clr[i] sets ovf[i]. ovf_clr=1 zeroes ovf, but a same-cycle overflow set wins. In EDGE_MODE=0, ovf stays 0.
- Encoder input is pending & mask, with encoder EN = en. Priority order: bit3 > bit2 > bit1 > bit0.
- FSM states:
  - IDLE: if en & |(pending & mask), go to ISSUE. On that transition, irq_id <= encoded id and irq_valid <= 1.
  - ISSUE: irq_id is frozen; higher-priority arrivals, mask changes and en=0 do not alter it. On ack=1, clear pending[irq_id], set irq_valid <= 0 and go to IDLE.
  - A new issue can happen no earlier than the cycle after ack, so there is a minimum one-cycle irq_valid low gap between grants.
- Latency: req rises before edge k → pending set after edge k → irq_valid=1 after edge k+1 (2 cycles), given en=1 and an unmasked channel in IDLE.
- Channel masked after issue: the grant still completes on ack.
- ack while irq_valid=0: ignored, no state change.
- rst during ISSUE: the grant is dropped without clear side-effects; everything returns to reset values.
- Unused FSM encodings return to IDLE.

Decomposition:
- Shared package/header irq_pkg:
  - state constants S_IDLE=1'b0, S_ISSUE=1'b1
  - NCH=4
  - ID_W=2
- Sub-module: reuse the existing combinational priority_enc_4to2, instantiated once with the masked pending vector and en.
- Edge detect and capture logic stay inline.

Test Plan:
1. Reset with req=4'b1111 held, then release: no edges, pending=0, irq_valid=0 for 5 cycles. Then drop req to 0 and pulse req=4'b0100 for one cycle: after 2 edges irq_valid=1, irq_id=2; ack → pending=0, irq_valid=0.
2. Pulse req=4'b0011 and req=4'b1000 on the same cycle (mask=4'b1111, en=1): issued in order 3, 1, 0, one ack each. irq_valid is low for ≥1 cycle between grants. pending sequence is 1011 → 0011 → 0001 → 0000.
3. Issue id=1, then pulse req[3] while in ISSUE: irq_id stays 1 until ack. The next grant is id=3.
4. Set mask=4'b0111 and pulse req=4'b1000: pending=1000 and irq_valid stays 0. Set mask=4'b1111: irq_valid=1 and irq_id=3 the next cycle.
5. Overflow: pulse req[0] twice with no ack → ovf=4'b0001. Pulse req[0] on the ack cycle of id 0 → pending[0] stays 1 and ovf does not change. ovf_clr → ovf=0.
6. en=0 with pending=4'b0010: no issue. Assert rst during ISSUE: all outputs zero the next cycle. With EDGE_MODE=0, holding req=4'b0001 re-issues id 0 after each ack.
